// File: rtl/matrix_block_accumulator.sv
// matrix_block_accumulator: a ROWS x COLS tile of single-precision accumulators.
// Each lane has one multi-cycle `adder`. The tile is either loaded directly
// (clear) or summed with the incoming tile. Lanes can finish on different
// cycles. The accumulators change in one step after every lane has finished.
// Optional watchdog: define ACC_TIMEOUT_EN to abort an ADD phase that runs
// for TIMEOUT cycles.

// adder: serial IEEE-754 single-precision adder, round-to-nearest-even.
// Alignment and normalisation shift one bit per cycle, so latency grows with
// the exponent difference (capped at 27 alignment steps). Denormal inputs and
// results are flushed to +0. Inf/NaN inputs are not treated specially.
module adder (
   input  logic        clk,
   input  logic        add_rst_n,
   input  logic        load,
   input  logic [31:0] number1,
   input  logic [31:0] number2,
   input  logic        result_ack,
   output logic [31:0] result,
   output logic        result_ready
);
   typedef enum logic [2:0] {A_IDLE, A_ALIGN, A_ADD, A_NORM, A_ROUND, A_HOLD} add_state_t;

   add_state_t  st;
   logic        sign_r, sub_r;
   logic [9:0]  exp_r;            // wide enough to see overflow past 254
   logic [27:0] big_m, small_m;   // [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky
   logic [4:0]  diff_r;

   logic [7:0]  e1, e2, ediff;
   logic [23:0] m1, m2;
   logic        swap, small_zero;
   logic        round_up;
   logic [24:0] rounded;
   logic [9:0]  exp_rnd;

   // Unpack both operands and order them so that big >= small in magnitude.
   // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
   always_comb begin
      e1         = number1[30:23];
      e2         = number2[30:23];
      m1         = (e1 == 8'h0) ? 24'h0 : {1'b1, number1[22:0]};
      m2         = (e2 == 8'h0) ? 24'h0 : {1'b1, number2[22:0]};
      swap       = {e2, m2} > {e1, m1};
      ediff      = swap ? (e2 - e1) : (e1 - e2);
      small_zero = swap ? (e1 == 8'h0) : (e2 == 8'h0);
   end

   // Round-to-nearest-even on the normalised sum.
   always_comb begin
      round_up = big_m[2] & (big_m[1] | big_m[0] | big_m[3]);
      rounded  = {1'b0, big_m[26:3]} + {24'h0, round_up};
      exp_rnd  = exp_r + {9'h0, rounded[24]};
   end

   // Sequencer: capture, align, add, normalise, round, then hold until acknowledged.
   // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!add_rst_n) begin
         st           <= A_IDLE;
         result       <= '0;
         result_ready <= 1'b0;
      end else begin
         unique case (st)
            A_IDLE: begin
               if (load) begin
                  big_m   <= {1'b0, swap ? m2 : m1, 3'b000};
                  small_m <= {1'b0, swap ? m1 : m2, 3'b000};
                  exp_r   <= {2'b00, swap ? e2 : e1};
                  sign_r  <= swap ? number2[31] : number1[31];
                  sub_r   <= number1[31] ^ number2[31];
                  diff_r  <= small_zero ? 5'd0 : ((ediff > 8'd27) ? 5'd27 : ediff[4:0]);
                  st      <= A_ALIGN;
               end
            end
            A_ALIGN: begin
               if (diff_r == 5'd0) begin
                  st <= A_ADD;
               end else begin
                  small_m <= {1'b0, small_m[27:2], small_m[1] | small_m[0]};
                  diff_r  <= diff_r - 5'd1;
               end
            end
            A_ADD: begin
               big_m <= sub_r ? (big_m - small_m) : (big_m + small_m);
               st    <= A_NORM;
            end
            A_NORM: begin
               if (big_m == 28'h0) begin
                  result       <= '0;
                  result_ready <= 1'b1;
                  st           <= A_HOLD;
               end else if (big_m[27]) begin
                  big_m <= {1'b0, big_m[27:2], big_m[1] | big_m[0]};
                  exp_r <= exp_r + 10'd1;
               end else if (!big_m[26]) begin
                  if (exp_r <= 10'd1) begin
                     result       <= '0;
                     result_ready <= 1'b1;
                     st           <= A_HOLD;
                  end else begin
                     big_m <= {big_m[26:0], 1'b0};
                     exp_r <= exp_r - 10'd1;
                  end
               end else begin
                  st <= A_ROUND;
               end
            end
            A_ROUND: begin
               if (exp_rnd >= 10'd255)
                  result <= {sign_r, 8'hFF, 23'h0};
               else
                  result <= {sign_r, exp_rnd[7:0], rounded[24] ? rounded[23:1] : rounded[22:0]};
               result_ready <= 1'b1;
               st           <= A_HOLD;
            end
            A_HOLD: begin
               if (result_ack) begin
                  result_ready <= 1'b0;
                  st           <= A_IDLE;
               end
            end
            default: st <= A_IDLE;
         endcase
      end
   end
endmodule

module matrix_block_accumulator #(
   parameter int ROWS    = 2,
   parameter int COLS    = 2,
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        i_clear,
   input  logic [ROWS*COLS*WIDTH-1:0]  i_data,
   output logic [ROWS*COLS*WIDTH-1:0]  o_data,
   output logic                        done,
   output logic                        busy,
   output logic [CNT_W-1:0]            acc_count,
   output logic                        timeout_err
);
   localparam int LANES = ROWS * COLS;
   localparam int LW    = LANES * WIDTH;

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, ADD, DONE} state_t;

   state_t           state;
   logic [LW-1:0]    acc;
   logic [LW-1:0]    opnd;
   logic [WIDTH-1:0] hold [LANES];
   logic [WIDTH-1:0] res  [LANES];
   logic [LANES-1:0] ready, flag, capture_en;
   logic             add_rst_n, load, ack;

   // Only the 32-bit adder exists, and the watchdog needs a positive limit.
   if (WIDTH != 32 || TIMEOUT < 1) begin : g_param_check
      $error("matrix_block_accumulator: WIDTH must be 32 and TIMEOUT >= 1");
   end

`ifdef ACC_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt, wd_next;
   assign wd_next = wd_cnt + 1'b1;
`else
   assign timeout_err = 1'b0;
`endif

   assign o_data     = acc;
   assign capture_en = {LANES{state == ADD}} & ready & ~flag;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      adder u_add (
         .clk          (clk),
         .add_rst_n    (add_rst_n),
         .load         (load),
         .number1      (acc[k*WIDTH +: WIDTH]),
         .number2      (opnd[k*WIDTH +: WIDTH]),
         .result_ack   (ack),
         .result       (res[k]),
         .result_ready (ready[k])
      );
   end

   // Park each lane's sum the first cycle its adder offers one during ADD.
   // NOTE: holding registers need no reset; a capture flag gates every read of them.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++)
         if (capture_en[k]) hold[k] <= res[k];
   end

   // Control FSM with registered outputs; reset discards any in-flight addition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         opnd      <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         acc_count <= '0;
         add_rst_n <= 1'b0;
         load      <= 1'b0;
         ack       <= 1'b0;
         flag      <= '0;
`ifdef ACC_TIMEOUT_EN
         timeout_err <= 1'b0;
         wd_cnt      <= '0;
`endif
      end else begin
         done <= 1'b0;
         load <= 1'b0;
         ack  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  opnd <= i_data;
                  busy <= 1'b1;
                  if (i_clear) begin
                     state <= LOAD;
                  end else begin
                     add_rst_n <= 1'b1;
                     load      <= 1'b1;
                     state     <= SETUP;
                  end
               end
            end
            LOAD: begin
               acc       <= opnd;
               acc_count <= '0;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            SETUP: begin
               flag  <= '0;
`ifdef ACC_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state <= ADD;
            end
            ADD: begin
               flag <= flag | capture_en;
               if (&flag) begin
                  // Whole tile moves at once so o_data never shows a mix of old and new lanes.
                  for (int k = 0; k < LANES; k++)
                     acc[k*WIDTH +: WIDTH] <= hold[k];
                  if (acc_count != '1) acc_count <= acc_count + 1'b1;
                  ack       <= 1'b1;
                  add_rst_n <= 1'b0;
                  state     <= DONE;
               end
`ifdef ACC_TIMEOUT_EN
               else if (wd_next == WD_W'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  ack         <= 1'b1;
                  add_rst_n   <= 1'b0;
                  state       <= DONE;
               end else begin
                  wd_cnt <= wd_next;
               end
`endif
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/matrix_block_accumulator.md
Name: matrix_block_accumulator

Overview:
Parametrised successor to the fixed 2x2 floating-point accumulator: ROWS x COLS lanes of IEEE-754 single-precision accumulators, one existing `adder` instance per lane. Sits after the block multiplier and sums partial product tiles into a result tile. Adds a direct-load (clear) mode, per-lane result capture for lanes that finish on different cycles, a busy flag and a saturating accumulation counter.

Parameters:
ROWS, 2, tile rows
COLS, 2, tile columns; LANES = ROWS*COLS
WIDTH, 32, lane width; only 32 is valid with `adder`
CNT_W, 16, accumulation counter width
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
i_clear  in  1  sampled with start; 1 = load tile into accumulators, bypassing addition
i_data  in  LANES*WIDTH  input tile; lane k = bits [k*WIDTH +: WIDTH], k = r*COLS + c
o_data  out  LANES*WIDTH  accumulator contents, same packing
done  out  1  one-cycle pulse when o_data is updated
busy  out  1  high in every state except IDLE
acc_count  out  CNT_W  accumulations since last clear/reset; saturates at all-ones
timeout_err  out  1  sticky watchdog flag; tied 0 without the feature

Behaviour:
- Adder contract, per lane: add_rst_n low holds the adder in reset. A one-cycle `load` latches Number1 (accumulator) and Number2 (captured input). `result_ready` rises when Result is valid and stays high until a one-cycle `result_ack`.
- Reset, synchronous: state=IDLE; all accumulators=32'h0 (+0.0); done=0; busy=0; acc_count=0; timeout_err=0; add_rst_n=0; load=0; ack=0; lane capture flags cleared. Reset overrides everything, including reset mid-operation; any in-flight addition is discarded.
- States and transitions:
  - IDLE: add_rst_n=0. On start, register i_data into the operand registers.
    - i_clear=1: go to LOAD.
    - i_clear=0: go to SETUP.
  - LOAD: accumulators = operand registers; acc_count=0; done=1; go to IDLE.
    - Latency from start to done: 2 cycles.
  - SETUP: add_rst_n=1; load=1 for exactly this cycle; clear capture flags; go to ADD.
  - ADD:
    - For each lane with result_ready=1 and capture flag 0: store Result into the lane's holding register and set its flag. Accumulators do not change yet.
    - When all flags are set: pulse ack for one cycle; copy all holding registers to the accumulators in the same cycle; acc_count += 1 (saturating); go to DONE.
  - DONE: done=1 for one cycle; add_rst_n=0; go to IDLE.
- o_data updates only on LOAD, on the ADD->DONE edge, and on reset. o_data never shows a partially updated tile.
- Ordering of done: in the non-clear path, done is asserted the cycle after o_data changes. In LOAD, done and the o_data change fall on the same edge.
- start is ignored while busy=1; no queuing.
- i_data may change after the start cycle.
- The next start is accepted in the first IDLE cycle after done, i.e. back-to-back with one idle cycle.
- acc_count at all-ones stays at all-ones. A clear resets it to 0.

Optional Feature:
Macro ACC_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) resets on entry to ADD and increments each ADD cycle.
  - If it reaches TIMEOUT before all flags are set: timeout_err=1 (sticky until reset); accumulators unchanged; acc_count unchanged; ack pulsed; go to DONE, so done still pulses.
- Undefined: no counter; timeout_err is driven constant 0; ADD waits indefinitely.

Test Plan:
- Reset, then start with i_clear=1 and all lanes=32'h3F800000 (1.0) -> done 2 cycles after start; o_data all 3F800000; acc_count=0; busy high for 1 cycle.
- From that state, start with i_clear=0 and lanes=40000000 (2.0) -> done after adder latency + 2; all lanes 40400000 (3.0); acc_count=1; exactly one ack pulse.
- Adder model with lane 0 ready 5 cycles later than the others -> o_data unchanged until the last lane is ready; then all lanes update on one edge; values correct.
- Assert start during ADD, then assert reset during ADD -> the start has no effect. After reset: o_data all 0, state IDLE, done never pulses, acc_count=0.
- Set acc_count to all-ones via forced CNT_W=2 and 4 accumulations -> acc_count holds at 3; a start with i_clear=1 returns it to 0.
- ACC_TIMEOUT_EN with TIMEOUT=8 and one lane never ready -> timeout_err=1 at ADD cycle 8; done pulses; o_data unchanged. Build without the macro: timeout_err stays 0.
